wb_arbiter2: RTL
================

# wb_arbiter2

Two-master Wishbone classic arbiter that shares one slave port (the SoC interconnect feeding SRAM, bootrom and UART) between the picorv32 instruction/data master and a second master such as a debug loader or DMA. Grants are registered and round-robin, and a grant is held for as long as the owner keeps its cycle (`cyc`) asserted. An optional bus watchdog terminates hung cycles with an error response.

## Interface
Parameters:
- `AW`, 32: address width.
- `DW`, 32: data width; `sel` width is `DW/8`.
- `TIMEOUT_CYCLES`, 255: watchdog limit in clocks. Legal range 1 to 65535.

Ports (`mN` means both `m0` and `m1`):
- `clock`, input, 1: single clock, rising edge.
- `reset`, input, 1: asynchronous, active-high.
- `mN_adr_i`, input, AW: master address.
- `mN_dat_i`, input, DW: master write data.
- `mN_sel_i`, input, DW/8: byte selects.
- `mN_we_i`, input, 1: write enable.
- `mN_cyc_i`, input, 1: bus request; held high for the whole cycle.
- `mN_stb_i`, input, 1: strobe.
- `mN_dat_o`, output, DW: read data; `s_dat_i` broadcast to both masters.
- `mN_ack_o`, output, 1: ack, driven to the owner only.
- `mN_err_o`, output, 1: error, driven to the owner only.
- `s_adr_o`, output, AW: owner address.
- `s_dat_o`, output, DW: owner write data.
- `s_sel_o`, output, DW/8: owner selects.
- `s_we_o`, output, 1: owner write enable.
- `s_cyc_o`, output, 1: `granted & owner_cyc`.
- `s_stb_o`, output, 1: `granted & owner_stb`.
- `s_dat_i`, input, DW: slave read data.
- `s_ack_i`, input, 1: slave ack.
- `s_err_i`, input, 1: slave error.

## Operation
States:
- **IDLE**: no grant.
- **GRANT0**: m0 owns the bus.
- **GRANT1**: m1 owns the bus.

Register `last` records the most recent owner. It resets to 1, so m0 wins the first tie.

Arbitration (from IDLE, or from a GRANTn state whose owner's `cyc` has been sampled low):
- Only one master has `cyc` high: grant it.
- Both have `cyc` high: grant the master that is not `last`.
- Neither has `cyc` high: go to IDLE.

Grant rules:
- While granted, the owner's `cyc` high keeps the grant. The other master waits and sees `ack`/`err` held at 0.
- Handover is direct, GRANT0 to GRANT1 without passing through IDLE, when the owner drops `cyc` and the other master is requesting.

Datapath:
- Slave-side outputs are a combinational mux of the owner's signals.
- When no master is granted, `s_cyc_o` and `s_stb_o` are 0; address, data, select and write enable take m0's values, which are don't-care.
- `s_ack_i` and `s_err_i` are routed combinationally to the owner only.

Reset:
- Mid-cycle reset returns to IDLE immediately. Masters must re-issue the cycle.
- Reset values: state IDLE, `s_cyc_o = s_stb_o = 0`, all `ack`/`err` outputs 0, watchdog counter 0.

## Timing
- Request to grant: 1 cycle. `mN_cyc_i` rising at edge k gives `s_cyc_o` high after edge k+1.
- Ack/err/read data path: 0 cycles, combinational.
- Handover gap: after the owner drops `cyc`, the next owner's `s_cyc_o` rises 1 cycle later.
- Pipelined back-to-back strobes within one `cyc` pass through without bubbles.
- Simultaneous drop of `cyc` by the owner and rise of the other master's `cyc`: the other master is granted on the next edge.

## Configuration
Macro `WB_ARBITER2_TIMEOUT_EN`.

When defined:
- A 16-bit counter increments each cycle that `s_stb_o` is high and both `s_ack_i` and `s_err_i` are low.
- The counter clears on `ack`, on `err`, when `stb` is low, or on a grant change.
- When the count reaches `TIMEOUT_CYCLES`:
  - the owner's `err_o` is asserted for exactly 1 cycle;
  - `s_cyc_o` and `s_stb_o` are forced low in that same cycle;
  - the counter clears;
  - the grant is retained.

When not defined: no counter is built, and `ack`/`err` are pure pass-through. A silent slave hangs the owner indefinitely.

## Structure
- Package `wb_arbiter2_pkg` holds:
  - the state enum (IDLE, GRANT0, GRANT1);
  - master-ID constants `M0 = 1'b0`, `M1 = 1'b1`;
  - the watchdog counter width constant, 16.
- Sub-module `wb_arbiter2_watchdog` contains the counter and the 1-cycle timeout pulse. It is instantiated only under `WB_ARBITER2_TIMEOUT_EN`.

## Test plan
- **Reset and default grant.** Release reset, then assert m0 and m1 `cyc` on the same edge. Expected: m0 is granted after 1 cycle and `s_adr_o` equals `m0_adr_i`.
- **Round-robin alternation.** Both masters request continuously, each issuing one access and then dropping `cyc`. Expected grant sequence: m0, m1, m0, m1, with a 1-cycle gap at each handover.
- **Grant hold.** m1 owns the bus and holds `cyc` through 3 strobes with the slave acking each. Meanwhile m0 requests. Expected: m0 sees `ack = 0` throughout; m0 is granted 1 cycle after m1 drops `cyc`.
- **Routing.** With m0 owning, the slave returns `s_dat_i = 0xDEADBEEF` together with `s_ack_i`. Expected: `m0_ack_o = 1`, `m1_ack_o = 0`, and both `dat_o` equal `0xDEADBEEF`. Repeat with `s_err_i` and check it is routed the same way to `m0_err_o` only.
- **Reset mid-cycle.** Assert reset while GRANT1 is active with `stb` high. Expected: `s_cyc_o` goes to 0 asynchronously, and the state is IDLE after reset deasserts.
- **Watchdog** (`WB_ARBITER2_TIMEOUT_EN`, `TIMEOUT_CYCLES = 8`). The slave never acks. Expected: `m0_err_o` pulses for 1 cycle, 8 cycles after `s_stb_o` rose; `s_stb_o` is low in that cycle; the grant stays with m0.

Source files
------------

// File: rtl/wb_arbiter2_pkg.sv
// -----------------------------------------------------------------------------
// wb_arbiter2_pkg
// Shared types and constants for the two-master Wishbone classic arbiter:
//   state_e     - arbiter grant state (IDLE, GRANT0, GRANT1)
//   M0 / M1     - master identifiers used for the round-robin 'last' register
//   WD_W        - width of the optional bus-watchdog stall counter
//   grant_state - maps a master ID onto its GRANTn state
// -----------------------------------------------------------------------------
package wb_arbiter2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_e;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  localparam int WD_W = 16;

  function automatic state_e grant_state(input logic id);
    return (id == M1) ? GRANT1 : GRANT0;
  endfunction

endpackage

// File: rtl/wb_arbiter2_watchdog.sv
// -----------------------------------------------------------------------------
// wb_arbiter2_watchdog
// Stall counter for the shared slave port. Counts clocks in which the owner's
// strobe is presented and the slave answers with neither ack nor err; when the
// count reaches TIMEOUT_CYCLES a single-cycle timeout pulse is produced.
//
// Parameters:
//   TIMEOUT_CYCLES - stall limit in clocks (1..65535)
// Ports:
//   clock        in   rising-edge clock
//   reset        in   asynchronous active-high reset
//   stb          in   owner strobe as seen by the slave (before forcing)
//   ack          in   slave ack
//   err          in   slave err
//   grant_change in   grant moves to a different state on the next edge
//   timeout      out  high for the one cycle in which the limit is reached
// -----------------------------------------------------------------------------
module wb_arbiter2_watchdog
  import wb_arbiter2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clock,
  input  logic reset,
  input  logic stb,
  input  logic ack,
  input  logic err,
  input  logic grant_change,
  output logic timeout
);

  localparam logic [WD_W-1:0] LIMIT = WD_W'(TIMEOUT_CYCLES);

  logic [WD_W-1:0] count;

  // The count equals the number of completed stalled cycles, so the pulse
  // lands TIMEOUT_CYCLES clocks after the strobe was first presented.
  assign timeout = (count == LIMIT);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (timeout || grant_change || !stb || ack || err) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/wb_arbiter2.sv
// -----------------------------------------------------------------------------
// wb_arbiter2
// Two-master Wishbone classic arbiter sharing one slave port. Grants are
// registered and round-robin; the owner keeps the bus while its cyc is high.
// Handover to a waiting master is direct (no IDLE pass) one clock after the
// owner drops cyc. Slave-side signals are a combinational mux of the owner;
// ack/err are routed to the owner only, read data is broadcast.
//
// Build option:
//   WB_ARBITER2_TIMEOUT_EN - when defined, a bus watchdog terminates a cycle
//   stalled for TIMEOUT_CYCLES clocks with a one-cycle err to the owner,
//   forcing s_cyc_o/s_stb_o low in that cycle and keeping the grant.
//
// Parameters: AW (address width), DW (data width), TIMEOUT_CYCLES (1..65535)
// Ports:
//   clock, reset                  clock, asynchronous active-high reset
//   mN_adr_i/dat_i/sel_i/we_i     master request fields (N = 0, 1)
//   mN_cyc_i, mN_stb_i            master cycle / strobe
//   mN_dat_o                      read data (s_dat_i to both masters)
//   mN_ack_o, mN_err_o            ack / err, owner only
//   s_adr_o/dat_o/sel_o/we_o      owner request fields (m0's when idle)
//   s_cyc_o, s_stb_o              granted & owner cyc / stb
//   s_dat_i, s_ack_i, s_err_i     slave response
// -----------------------------------------------------------------------------
module wb_arbiter2
  import wb_arbiter2_pkg::*;
#(
  parameter int AW             = 32,
  parameter int DW             = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [AW-1:0] m0_adr_i,
  input  logic [DW-1:0] m0_dat_i,
  input  logic [DW/8-1:0] m0_sel_i,
  input  logic          m0_we_i,
  input  logic          m0_cyc_i,
  input  logic          m0_stb_i,
  output logic [DW-1:0] m0_dat_o,
  output logic          m0_ack_o,
  output logic          m0_err_o,
  input  logic [AW-1:0] m1_adr_i,
  input  logic [DW-1:0] m1_dat_i,
  input  logic [DW/8-1:0] m1_sel_i,
  input  logic          m1_we_i,
  input  logic          m1_cyc_i,
  input  logic          m1_stb_i,
  output logic [DW-1:0] m1_dat_o,
  output logic          m1_ack_o,
  output logic          m1_err_o,
  output logic [AW-1:0] s_adr_o,
  output logic [DW-1:0] s_dat_o,
  output logic [DW/8-1:0] s_sel_o,
  output logic          s_we_o,
  output logic          s_cyc_o,
  output logic          s_stb_o,
  input  logic [DW-1:0] s_dat_i,
  input  logic          s_ack_i,
  input  logic          s_err_i
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("wb_arbiter2: TIMEOUT_CYCLES must be in 1..65535");
  end

  state_e state, state_next;
  logic   last, last_next;

  logic granted;
  logic sel_m1;
  logic owner_cyc;
  logic owner_stb;
  logic timeout;

  assign granted   = (state != IDLE);
  // Idle falls onto m0 so the slave side shows m0's (don't-care) fields.
  assign sel_m1    = (state == GRANT1);
  assign owner_cyc = sel_m1 ? m1_cyc_i : m0_cyc_i;
  assign owner_stb = sel_m1 ? m1_stb_i : m0_stb_i;

  // ---------------------------------------------------------------------------
  // Grant FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave it unassigned and infer a latch.
    state_next = state;
    last_next  = last;
    // Re-arbitrate when nobody holds the bus or the owner has released cyc;
    // the released owner's cyc is low here, so a tie cannot re-pick it.
    if (!granted || !owner_cyc) begin
      if (m0_cyc_i && m1_cyc_i) begin
        state_next = grant_state(~last);
      end else if (m0_cyc_i) begin
        state_next = GRANT0;
      end else if (m1_cyc_i) begin
        state_next = GRANT1;
      end else begin
        state_next = IDLE;
      end
    end
    if (state_next != IDLE) begin
      last_next = (state_next == GRANT1) ? M1 : M0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    // NOTE: registered state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    if (reset) begin
      state <= IDLE;
      last  <= M1;    // m0 wins the first tie
    end else begin
      state <= state_next;
      last  <= last_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Optional bus watchdog
  // ---------------------------------------------------------------------------
`ifdef WB_ARBITER2_TIMEOUT_EN
  wb_arbiter2_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clock        (clock),
    .reset        (reset),
    .stb          (granted & owner_stb),
    .ack          (s_ack_i),
    .err          (s_err_i),
    .grant_change (state_next != state),
    .timeout      (timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  assign s_adr_o = sel_m1 ? m1_adr_i : m0_adr_i;
  assign s_dat_o = sel_m1 ? m1_dat_i : m0_dat_i;
  assign s_sel_o = sel_m1 ? m1_sel_i : m0_sel_i;
  assign s_we_o  = sel_m1 ? m1_we_i  : m0_we_i;
  assign s_cyc_o = granted & owner_cyc & ~timeout;
  assign s_stb_o = granted & owner_stb & ~timeout;

  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign m0_ack_o = (state == GRANT0) & s_ack_i;
  assign m1_ack_o = (state == GRANT1) & s_ack_i;
  assign m0_err_o = (state == GRANT0) & (s_err_i | timeout);
  assign m1_err_o = (state == GRANT1) & (s_err_i | timeout);

endmodule
